// File: rtl/msx_mouse_port.sv
// Converts host mouse reports into the MSX port-A mouse protocol.
// Motion is accumulated between reads and served as four nibbles sequenced by STRA toggles.
module msx_mouse_port #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ACC_W          = 11
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic       mouse_strobe,
    input  logic       joy_idle,
    input  logic       stra,
    output logic       mouse_en,
    output logic [5:0] port_out
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SUM_W = ACC_W + 2;
    localparam logic [CNT_W-1:0]         CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic signed [SUM_W-1:0]  ACC_MAX  = SUM_W'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [SUM_W-1:0]  ACC_MIN  = SUM_W'(-(2 ** (ACC_W - 1)));
    localparam logic signed [ACC_W-1:0]  B_MAX    = ACC_W'(127);
    localparam logic signed [ACC_W-1:0]  B_MIN    = ACC_W'(-128);

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
        else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
        else                  return v[ACC_W-1:0];
    endfunction

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > B_MAX)      return 8'h7F;
        else if (v < B_MIN) return 8'h80;
        else                return v[7:0];
    endfunction

    state_t                   state_r;
    logic                     stra_d_r;
    logic [CNT_W-1:0]         cnt_r;
    logic signed [ACC_W-1:0]  acc_x_r, acc_y_r;
    logic [7:0]               snap_x_r, snap_y_r;

    logic                     edge_s, en_next_s, unused_flags_s;
    logic signed [ACC_W-1:0]  base_x_s, base_y_s, acc_x_next_s, acc_y_next_s;
    logic signed [SUM_W-1:0]  sum_x_s, sum_y_s;
    logic [7:0]               snap8_x_s, snap8_y_s;

    assign unused_flags_s = ^mouse_flags[7:2];

    // Edge detect, enable decision and saturating accumulator next values
    always_comb begin
        edge_s    = stra ^ stra_d_r;
        en_next_s = mouse_strobe | (mouse_en & joy_idle);
        // a read snapshot in S0 empties the accumulator before any coincident delta lands
        base_x_s  = (edge_s && (state_r == S0)) ? '0 : acc_x_r;
        base_y_s  = (edge_s && (state_r == S0)) ? '0 : acc_y_r;
        sum_x_s   = {{(SUM_W-ACC_W){base_x_s[ACC_W-1]}}, base_x_s}
                  - {{(SUM_W-9){mouse_x[8]}}, mouse_x};
        sum_y_s   = {{(SUM_W-ACC_W){base_y_s[ACC_W-1]}}, base_y_s}
                  + {{(SUM_W-9){mouse_y[8]}}, mouse_y};
        snap8_x_s = sat8(acc_x_r);
        snap8_y_s = sat8(acc_y_r);
        if (mouse_strobe) begin
            acc_x_next_s = sat_acc(sum_x_s);
            acc_y_next_s = sat_acc(sum_y_s);
        end else begin
            acc_x_next_s = base_x_s;
            acc_y_next_s = base_y_s;
        end
    end

    // Mode select, accumulators, nibble sequencer and read timeout
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mouse_en <= 1'b0;
            port_out <= 6'h3F;
            state_r  <= S0;
            stra_d_r <= 1'b0;
            cnt_r    <= '0;
            acc_x_r  <= '0;
            acc_y_r  <= '0;
            snap_x_r <= 8'h00;
            snap_y_r <= 8'h00;
        end else begin
            stra_d_r <= stra;
            mouse_en <= en_next_s;
            if (edge_s)              cnt_r <= CNT_LOAD;
            else if (cnt_r != '0)    cnt_r <= cnt_r - CNT_ONE;
            else                     cnt_r <= cnt_r;

            if (!en_next_s) begin
                port_out <= 6'h3F;
                acc_x_r  <= '0;
                acc_y_r  <= '0;
                state_r  <= S0;
            end else begin
                acc_x_r <= acc_x_next_s;
                acc_y_r <= acc_y_next_s;
                if (mouse_strobe) port_out[5:4] <= ~mouse_flags[1:0];
                if (edge_s) begin
                    case (state_r)
                        S0: begin
                            snap_x_r      <= snap8_x_s;
                            snap_y_r      <= snap8_y_s;
                            port_out[3:0] <= snap8_x_s[7:4];
                            state_r       <= S1;
                        end
                        S1: begin
                            port_out[3:0] <= snap_x_r[3:0];
                            state_r       <= S2;
                        end
                        S2: begin
                            port_out[3:0] <= snap_y_r[7:4];
                            state_r       <= S3;
                        end
                        S3: begin
                            port_out[3:0] <= snap_y_r[3:0];
                            state_r       <= S0;
                        end
                        default: state_r <= S0;
                    endcase
                end else if (cnt_r == CNT_ONE) begin
                    // host stopped reading mid-sequence: restart, keep last nibble on the pins
                    state_r <= S0;
                end else begin
                    state_r <= state_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_msx_mouse_port.sv
// Self-checking bench for msx_mouse_port: vector table plus hand sequences, scoreboard-compared.
module tb_msx_mouse_port;
    localparam int TO = 40;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] mouse_x = 9'd0;
    logic [8:0] mouse_y = 9'd0;
    logic [7:0] mouse_flags = 8'd0;
    logic       mouse_strobe = 1'b0;
    logic       joy_idle = 1'b1;
    logic       stra = 1'b0;
    logic       mouse_en;
    logic [5:0] port_out;

    msx_mouse_port #(.TIMEOUT_CYCLES(TO), .ACC_W(11)) dut (
        .clk_sys(clk_sys), .reset(reset), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .mouse_flags(mouse_flags), .mouse_strobe(mouse_strobe), .joy_idle(joy_idle),
        .stra(stra), .mouse_en(mouse_en), .port_out(port_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       rst;
        logic       stb;
        logic [8:0] x;
        logic [8:0] y;
        logic [1:0] fl;
        logic       idle;
        logic       st;
        logic       en;
        logic [5:0] po;
    } vec_t;

    typedef struct {
        logic       en;
        logic [5:0] po;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic stra_v = 1'b0;
    vec_t tbl[33];

    function automatic vec_t mk(input logic rst, input logic stb, input logic [8:0] x,
                                input logic [8:0] y, input logic [1:0] fl, input logic idle,
                                input logic st, input logic en, input logic [5:0] po);
        vec_t v;
        v.rst = rst; v.stb = stb; v.x = x; v.y = y; v.fl = fl;
        v.idle = idle; v.st = st; v.en = en; v.po = po;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clk_sys);
        reset        = v.rst;
        mouse_strobe = v.stb;
        mouse_x      = v.x;
        mouse_y      = v.y;
        mouse_flags  = {6'b101010, v.fl};
        joy_idle     = v.idle;
        stra         = v.st;
        e.en = v.en;
        e.po = v.po;
        sb.push_back(e);
        @(posedge clk_sys);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (mouse_en !== e.en || port_out !== e.po) begin
                errors++;
                $display("FAIL %s: got en=%0b port_out=%h, expected en=%0b port_out=%h",
                         name, mouse_en, port_out, e.en, e.po);
            end
        end
    endtask

    // One enabled-path cycle with y=0, no buttons; tog flips STRA
    task automatic cyc(input logic stb, input logic [8:0] x, input logic tog,
                       input logic en, input logic [5:0] po, input string name);
        if (tog) stra_v = ~stra_v;
        apply(mk(1'b0, stb, x, 9'd0, 2'b00, 1'b1, stra_v, en, po), name);
    endtask

    initial begin
        //            rst   stb   x       y       fl     idle  st    en    po
        tbl[0]  = mk(1'b0, 1'b1, 9'd5,   9'd3,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3F);
        tbl[1]  = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h3F);
        tbl[2]  = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3B);
        tbl[3]  = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h30);
        tbl[4]  = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h33);
        tbl[5]  = mk(1'b0, 1'b1, 9'd0,   9'd0,   2'b01, 1'b1, 1'b0, 1'b1, 6'h23);
        tbl[6]  = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b0, 1'b0, 1'b0, 6'h3F);
        tbl[7]  = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b0, 6'h3F);
        tbl[8]  = mk(1'b0, 1'b1, 9'd100, 9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3F);
        tbl[9]  = mk(1'b0, 1'b1, 9'd100, 9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3F);
        tbl[10] = mk(1'b0, 1'b1, 9'd100, 9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3F);
        tbl[11] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h38);
        tbl[12] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h30);
        tbl[13] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h30);
        tbl[14] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h30);
        tbl[15] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h30);
        tbl[16] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h30);
        tbl[17] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h30);
        tbl[18] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h30);
        tbl[19] = mk(1'b0, 1'b1, 9'h1F9, 9'h025, 2'b00, 1'b1, 1'b0, 1'b1, 6'h30);
        tbl[20] = mk(1'b0, 1'b1, 9'd2,   9'd1,   2'b00, 1'b1, 1'b1, 1'b1, 6'h30);
        tbl[21] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h37);
        tbl[22] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h32);
        tbl[23] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h35);
        tbl[24] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h3F);
        tbl[25] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3E);
        tbl[26] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h30);
        tbl[27] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h31);
        tbl[28] = mk(1'b0, 1'b1, 9'h138, 9'h1FB, 2'b00, 1'b1, 1'b0, 1'b1, 6'h31);
        tbl[29] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h37);
        tbl[30] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3F);
        tbl[31] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b1, 1'b1, 6'h3F);
        tbl[32] = mk(1'b0, 1'b0, 9'd0,   9'd0,   2'b00, 1'b1, 1'b0, 1'b1, 6'h3B);

        apply(mk(1'b1, 1'b0, 9'd0, 9'd0, 2'b00, 1'b1, 1'b0, 1'b0, 6'h3F), "reset0");
        apply(mk(1'b1, 1'b0, 9'd0, 9'd0, 2'b00, 1'b1, 1'b0, 1'b0, 6'h3F), "reset1");
        for (int i = 0; i < 33; i++) apply(tbl[i], $sformatf("vec%0d", i));
        stra_v = 1'b0;

        // Read in progress but host keeps up: no restart before the timeout expires
        cyc(1'b1, 9'h1EE, 1'b0, 1'b1, 6'h3B, "nto_strobe");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h31, "nto_e0");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h32, "nto_e1");
        for (int i = 0; i < TO - 3; i++) cyc(1'b0, 9'd0, 1'b0, 1'b1, 6'h32, "nto_wait");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h30, "nto_e2");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h30, "nto_e3");

        // Stalled read: timeout restarts the sequence, nibble held meanwhile
        cyc(1'b1, 9'h1EE, 1'b0, 1'b1, 6'h30, "to_strobe");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h31, "to_e0");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h32, "to_e1");
        for (int i = 0; i < TO + 2; i++) cyc(1'b0, 9'd0, 1'b0, 1'b1, 6'h32, "to_wait");
        cyc(1'b1, 9'h1CC, 1'b0, 1'b1, 6'h32, "to_strobe2");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h33, "to_restart");

        // Reset in S2 discards the read; next read starts with X high nibble
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h34, "rst_e1");
        apply(mk(1'b1, 1'b0, 9'd0, 9'd0, 2'b00, 1'b1, stra_v, 1'b0, 6'h3F), "rst_mid");
        cyc(1'b0, 9'd0,   1'b0, 1'b0, 6'h3F, "rst_idle");
        cyc(1'b1, 9'h1AA, 1'b0, 1'b1, 6'h3F, "rst_strobe");
        cyc(1'b0, 9'd0,   1'b1, 1'b1, 6'h35, "rst_e0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
